// File: rtl/poly_unpacker.sv
// Streams a packed LSB-first byte array into zero-extended coefficients,
// flagging any coefficient at or above Q.
module poly_unpacker #(
  parameter int COEF_W  = 14,
  parameter int N       = 1024,
  parameter int Q       = 12289,
  parameter int BYTE_AW = 11,
  parameter int POLY_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [BYTE_AW-1:0] byte_base_i,
  input  logic [POLY_AW-1:0] poly_base_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               range_err_o,
  output logic               byte_en_o,
  output logic [BYTE_AW-1:0] byte_addr_o,
  input  logic [7:0]         byte_do_i,
  output logic               poly_we_o,
  output logic [POLY_AW-1:0] poly_addr_o,
  output logic [15:0]        poly_di_o
);

  localparam int B   = N * COEF_W / 8;
  localparam int AW  = COEF_W + 24;
  localparam int CW  = 6;
  localparam int BCW = $clog2(B + 1);
  localparam int KCW = $clog2(N + 1);

  localparam logic [CW-1:0]   WC   = CW'(COEF_W);
  localparam logic [CW+1:0]   WP   = (CW+2)'(COEF_W);
  localparam logic [CW+1:0]   THR  = (CW+2)'(COEF_W + 7);
  localparam logic [BCW-1:0]  BLIM = BCW'(B);
  localparam logic [KCW-1:0]  KLST = KCW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d, acc_sh;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_sh;
  logic [BCW-1:0]     rd_q, rd_d;
  logic [KCW-1:0]     wr_q, wr_d;
  logic [BYTE_AW-1:0] bptr_q, bptr_d, bptr;
  logic [POLY_AW-1:0] pptr_q, pptr_d;
  logic               vld_q;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rerr_q, rerr_d;
  logic               ben_q, ben_d;
  logic [BYTE_AW-1:0] baddr_q, baddr_d;
  logic               pwe_q, pwe_d;
  logic [POLY_AW-1:0] paddr_q, paddr_d;
  logic [15:0]        pdi_q, pdi_d;
  logic               emit, issue;
  logic [CW+1:0]      proj;
  logic [COEF_W-1:0]  coef;

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    bptr_d  = bptr_q;
    pptr_d  = pptr_q;
    rerr_d  = rerr_q;
    done_d  = (state_q == DONE);
    ben_d   = 1'b0;
    baddr_d = '0;
    pwe_d   = 1'b0;
    paddr_d = '0;
    pdi_d   = '0;
    issue   = 1'b0;
    bptr    = bptr_q;
    coef    = acc_q[COEF_W-1:0];
    emit    = (state_q == RUN) && (cnt_q >= WC);
    acc_sh  = emit ? (acc_q >> COEF_W) : acc_q;
    cnt_sh  = emit ? (cnt_q - WC) : cnt_q;
    acc_d   = acc_sh;
    cnt_d   = cnt_sh;
    if (vld_q) begin
      acc_d = acc_sh | (AW'(byte_do_i) << cnt_sh);
      cnt_d = cnt_sh + CW'(8);
    end
    // Fill level one cycle ahead: in-flight byte in, pending extraction out.
    proj = {2'b00, cnt_d} + {{(CW-2){1'b0}}, ben_q, 3'b000};
    if (cnt_d >= WC)
      proj = proj - WP;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          acc_d   = '0;
          cnt_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
          bptr    = byte_base_i;
          pptr_d  = poly_base_i;
          rerr_d  = 1'b0;
          issue   = 1'b1;
        end
      end
      RUN: begin
        issue = (rd_q < BLIM) && (proj <= THR);
        if (emit && wr_q == KLST)
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (issue) begin
      ben_d   = 1'b1;
      baddr_d = bptr;
      bptr_d  = bptr + BYTE_AW'(1);
      rd_d    = rd_d + BCW'(1);
    end
    if (emit) begin
      pwe_d   = 1'b1;
      paddr_d = pptr_q;
      pptr_d  = pptr_q + POLY_AW'(1);
      pdi_d   = 16'(coef);
      wr_d    = wr_q + KCW'(1);
      if (32'(coef) >= 32'(Q))
        rerr_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      bptr_q  <= '0;
      pptr_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      ben_q   <= 1'b0;
      baddr_q <= '0;
      pwe_q   <= 1'b0;
      paddr_q <= '0;
      pdi_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      bptr_q  <= bptr_d;
      pptr_q  <= pptr_d;
      vld_q   <= ben_q;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
      ben_q   <= ben_d;
      baddr_q <= baddr_d;
      pwe_q   <= pwe_d;
      paddr_q <= paddr_d;
      pdi_q   <= pdi_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign range_err_o = rerr_q;
  assign byte_en_o   = ben_q;
  assign byte_addr_o = baddr_q;
  assign poly_we_o   = pwe_q;
  assign poly_addr_o = paddr_q;
  assign poly_di_o   = pdi_q;

endmodule
